signal_trace_writer: RTL and testbench

- Upstream producer for the VGA waveform display's shared signal memory.
- Accepts paired 12-bit ECG/EMG samples through a valid/ready handshake and decimates them.
- Scales each decimated sample to the 0..179 pixel trace height and writes it into two 320-entry circular trace windows.
- Maintains running raw min/max statistics and writes them to the four statistics words the display preloads.

---
 rtl/signal_trace_writer.sv | 209 ++++++++++++++++++++
 tb/tb_signal_trace_writer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_trace_writer.sv
// Decimates paired ECG/EMG samples into two circular trace windows and running min/max stats.
// Optional macro TRACE_AVERAGE_EN: trace columns use the group mean instead of the last sample.
module signal_trace_writer #(
    parameter int unsigned DECIM_LOG2 = 2,
    parameter logic [11:0] ECG_BASE   = 12'h559,
    parameter logic [11:0] EMG_BASE   = 12'h6AD,
    parameter logic [11:0] STAT_BASE  = 12'h6A9,
    parameter int unsigned TRACE_LEN  = 320
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [11:0] ecg_sample,
    input  logic [11:0] emg_sample,
    input  logic        clear,
    output logic        mem_wEn,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_data,
    output logic [8:0]  wr_ptr,
    output logic        busy
);
    localparam int unsigned      CNT_W       = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'((1 << DECIM_LOG2) - 1);
    localparam logic [8:0]       PTR_LAST    = 9'(TRACE_LEN - 1);
    localparam logic [10:0]      WIPE_LEN    = 11'(2 * TRACE_LEN);
    localparam logic [10:0]      TRACE_LEN_W = 11'(TRACE_LEN);

    typedef enum logic [2:0] {StWipe, StIdle, StWrEcg, StWrEmg, StWrStat} state_e;

    state_e           state_q;
    logic [10:0]      wipe_idx_q;
    logic [1:0]       stat_idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [8:0]       ptr_q;
    logic [11:0]      min_ecg_q, min_emg_q, max_ecg_q, max_emg_q;
    logic [7:0]       col_emg_q;
    logic             clear_pend_q;
    logic             wen_q, ready_q, busy_q;
    logic [11:0]      addr_q;
    logic [31:0]      data_q;

    logic        accept, wrap;
    logic [7:0]  col_ecg, col_emg;
    logic [11:0] wipe_addr;
    logic [11:0] stat_next;
    logic [1:0]  stat_idx_nx;

    // 0..4095 maps onto the 0..179 pixel trace height.
    function automatic logic [7:0] scale(input logic [11:0] s);
        logic [17:0] p;
        p = 18'(s) * 18'd45;
        return 8'(p >> 10);
    endfunction

    assign accept = (state_q == StIdle) && ready_q && sample_valid && !clear;
    assign wrap   = accept && (cnt_q == CNT_MAX);

`ifdef TRACE_AVERAGE_EN
    logic [17:0] acc_ecg_q, acc_emg_q, sum_ecg, sum_emg;

    // The sum includes the sample accepted this cycle, so the wrap column sees the whole group.
    assign sum_ecg = acc_ecg_q + 18'(ecg_sample);
    assign sum_emg = acc_emg_q + 18'(emg_sample);
    assign col_ecg = scale(12'(sum_ecg >> DECIM_LOG2));
    assign col_emg = scale(12'(sum_emg >> DECIM_LOG2));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_ecg_q <= '0;
            acc_emg_q <= '0;
        end else if (state_q == StWipe || wrap) begin
            acc_ecg_q <= '0;
            acc_emg_q <= '0;
        end else if (accept) begin
            acc_ecg_q <= sum_ecg;
            acc_emg_q <= sum_emg;
        end
    end
`else
    assign col_ecg = scale(ecg_sample);
    assign col_emg = scale(emg_sample);
`endif

    always_comb begin
        wipe_addr = (wipe_idx_q < TRACE_LEN_W) ? ECG_BASE + 12'(wipe_idx_q)
                                               : EMG_BASE + 12'(wipe_idx_q - TRACE_LEN_W);
        stat_idx_nx = stat_idx_q + 2'd1;
        stat_next   = min_ecg_q;
        case (stat_idx_nx)
            2'd1:    stat_next = min_emg_q;
            2'd2:    stat_next = max_ecg_q;
            2'd3:    stat_next = max_emg_q;
            default: stat_next = min_ecg_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StWipe;
            wipe_idx_q   <= '0;
            stat_idx_q   <= '0;
            cnt_q        <= '0;
            ptr_q        <= '0;
            min_ecg_q    <= 12'hFFF;
            min_emg_q    <= 12'hFFF;
            max_ecg_q    <= '0;
            max_emg_q    <= '0;
            col_emg_q    <= '0;
            clear_pend_q <= 1'b0;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            wen_q <= 1'b0;
            // A clear seen mid-sequence is held until the sequence would return to idle.
            if (clear && state_q != StIdle && state_q != StWipe) clear_pend_q <= 1'b1;

            unique case (state_q)
                StWipe: begin
                    ptr_q        <= '0;
                    cnt_q        <= '0;
                    min_ecg_q    <= 12'hFFF;
                    min_emg_q    <= 12'hFFF;
                    max_ecg_q    <= '0;
                    max_emg_q    <= '0;
                    clear_pend_q <= 1'b0;
                    if (clear) begin
                        wipe_idx_q <= '0;
                    end else if (wipe_idx_q < WIPE_LEN) begin
                        wen_q      <= 1'b1;
                        addr_q     <= wipe_addr;
                        data_q     <= '0;
                        wipe_idx_q <= wipe_idx_q + 11'd1;
                    end else begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                StIdle: begin
                    if (clear) begin
                        state_q    <= StWipe;
                        wipe_idx_q <= '0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                    end else if (accept) begin
                        if (ecg_sample < min_ecg_q) min_ecg_q <= ecg_sample;
                        if (emg_sample < min_emg_q) min_emg_q <= emg_sample;
                        if (ecg_sample > max_ecg_q) max_ecg_q <= ecg_sample;
                        if (emg_sample > max_emg_q) max_emg_q <= emg_sample;
                        if (wrap) begin
                            cnt_q     <= '0;
                            col_emg_q <= col_emg;
                            state_q   <= StWrEcg;
                            ready_q   <= 1'b0;
                            busy_q    <= 1'b1;
                            wen_q     <= 1'b1;
                            addr_q    <= ECG_BASE + 12'(ptr_q);
                            data_q    <= 32'(col_ecg);
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StWrEcg: begin
                    wen_q   <= 1'b1;
                    addr_q  <= EMG_BASE + 12'(ptr_q);
                    data_q  <= 32'(col_emg_q);
                    state_q <= StWrEmg;
                end
                StWrEmg: begin
                    ptr_q      <= (ptr_q == PTR_LAST) ? 9'd0 : ptr_q + 9'd1;
                    wen_q      <= 1'b1;
                    addr_q     <= STAT_BASE;
                    data_q     <= 32'(min_ecg_q);
                    stat_idx_q <= 2'd0;
                    state_q    <= StWrStat;
                end
                StWrStat: begin
                    if (stat_idx_q != 2'd3) begin
                        wen_q      <= 1'b1;
                        addr_q     <= STAT_BASE + 12'(stat_idx_nx);
                        data_q     <= 32'(stat_next);
                        stat_idx_q <= stat_idx_nx;
                    end else if (clear_pend_q || clear) begin
                        state_q    <= StWipe;
                        wipe_idx_q <= '0;
                    end else begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= StWipe;
            endcase
        end
    end

    assign sample_ready = ready_q;
    assign mem_wEn      = wen_q;
    assign mem_addr     = addr_q;
    assign mem_data     = data_q;
    assign wr_ptr       = ptr_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_signal_trace_writer.sv
// Scoreboard bench for signal_trace_writer: random samples against a queue-based reference model.
module tb_signal_trace_writer;
    localparam int DL2   = 2;
    localparam int DECIM = 1 << DL2;
    localparam int TLEN  = 320;
    localparam int ECGB  = 'h559;
    localparam int EMGB  = 'h6AD;
    localparam int STATB = 'h6A9;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [11:0] ecg_sample = '0;
    logic [11:0] emg_sample = '0;
    logic        clear = 1'b0;
    logic        mem_wEn;
    logic [11:0] mem_addr;
    logic [31:0] mem_data;
    logic [8:0]  wr_ptr;
    logic        busy;

    signal_trace_writer #(
        .DECIM_LOG2(DL2),
        .ECG_BASE  (12'h559),
        .EMG_BASE  (12'h6AD),
        .STAT_BASE (12'h6A9),
        .TRACE_LEN (TLEN)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .ecg_sample  (ecg_sample),
        .emg_sample  (emg_sample),
        .clear       (clear),
        .mem_wEn     (mem_wEn),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .wr_ptr      (wr_ptr),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: expected write stream plus the trace/stat state it implies.
    logic [43:0] exp_q[$];
    int m_ptr;
    int m_min_e, m_min_m, m_max_e, m_max_m;
    int grp_e[$];
    int grp_m[$];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int col_of(input int s);
        return (s * 45) / 1024;
    endfunction

    task automatic push_wr(input int addr, input int data);
        exp_q.push_back({12'(addr), 32'(data)});
    endtask

    task automatic model_wipe();
        for (int i = 0; i < TLEN; i++) push_wr(ECGB + i, 0);
        for (int i = 0; i < TLEN; i++) push_wr(EMGB + i, 0);
        m_ptr = 0;
        m_min_e = 4095; m_min_m = 4095;
        m_max_e = 0;    m_max_m = 0;
        grp_e.delete();
        grp_m.delete();
    endtask

    task automatic model_accept(input int e, input int m, output bit dec);
        int ce, cm, se, sm;
        dec = 0;
        if (e < m_min_e) m_min_e = e;
        if (m < m_min_m) m_min_m = m;
        if (e > m_max_e) m_max_e = e;
        if (m > m_max_m) m_max_m = m;
        grp_e.push_back(e);
        grp_m.push_back(m);
        if (grp_e.size() == DECIM) begin
`ifdef TRACE_AVERAGE_EN
            se = 0; sm = 0;
            foreach (grp_e[i]) begin se += grp_e[i]; sm += grp_m[i]; end
            ce = col_of(se / DECIM);
            cm = col_of(sm / DECIM);
`else
            se = 0; sm = 0;
            ce = col_of(grp_e[DECIM-1]);
            cm = col_of(grp_m[DECIM-1]);
`endif
            push_wr(ECGB + m_ptr, ce);
            push_wr(EMGB + m_ptr, cm);
            push_wr(STATB + 0, m_min_e);
            push_wr(STATB + 1, m_min_m);
            push_wr(STATB + 2, m_max_e);
            push_wr(STATB + 3, m_max_m);
            m_ptr = (m_ptr + 1) % TLEN;
            grp_e.delete();
            grp_m.delete();
            dec = 1;
        end
    endtask

    // Monitor: every write the DUT presents must match the head of the expected stream.
    initial begin
        logic [43:0] e;
        forever begin
            @(negedge clock);
            if (reset && mem_wEn) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL write_unexpected: got addr=%h data=%h expected no write",
                             mem_addr, mem_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({mem_addr, mem_data} != e) begin
                        bad++;
                        $display("FAIL write: got addr=%h data=%h expected addr=%h data=%h",
                                 mem_addr, mem_data, e[43:32], e[31:0]);
                    end
                end
            end
        end
    end

    task automatic count_lows(input int bound, output int n);
        n = 0;
        @(negedge clock);
        while (!sample_ready && n < bound) begin
            n++;
            @(negedge clock);
        end
    endtask

    // mode: 0 plain, 1 clear together with valid in idle, 2 clear during WR_EMG,
    // 3 asynchronous reset during the stat writes.
    task automatic send(input int e, input int m, input int mode);
        int waited, n;
        bit dec;
        waited = 0;
        @(negedge clock);
        while (!sample_ready && waited < 1000) begin
            @(negedge clock);
            waited++;
        end
        if (!sample_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        ecg_sample   = 12'(e);
        emg_sample   = 12'(m);
        sample_valid = 1'b1;
        if (mode == 1) clear = 1'b1;
        @(posedge clock);
        dec = 0;
        if (mode == 1) model_wipe();
        else model_accept(e, m, dec);
        #1;
        sample_valid = 1'b0;
        clear = 1'b0;
        if (mode == 1) begin
            count_lows(2000, n);
            check("ready_low_after_idle_clear", n, 641);
            check("wr_ptr_after_clear", wr_ptr, 0);
        end else if (dec && mode == 2) begin
            @(negedge clock);
            @(negedge clock);
            clear = 1'b1;
            @(posedge clock);
            model_wipe();
            #1 clear = 1'b0;
            count_lows(2000, n);
            check("ready_low_after_pending_clear", n, 645);
            check("wr_ptr_after_clear", wr_ptr, 0);
        end else if (dec && mode == 3) begin
            repeat (3) @(negedge clock);
            #2 reset = 1'b0;
            #1;
            check("async_reset_wen", mem_wEn, 0);
            check("async_reset_busy", busy, 1);
            check("async_reset_ptr", wr_ptr, 0);
            exp_q.delete();
            model_wipe();
            @(negedge clock);
            reset = 1'b1;
            count_lows(2000, n);
            check("ready_low_after_reset", n, 640);
        end else if (dec) begin
            count_lows(100, n);
            check("ready_low_cycles", n, 6);
            check("wr_ptr", wr_ptr, m_ptr);
        end
    endtask

    function automatic int rnd_sample();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return 0;
        if (r == 1) return 4095;
        return int'($urandom_range(0, 4095));
    endfunction

    initial begin
        int n;
        repeat (3) @(negedge clock);
        check("reset_wen", mem_wEn, 0);
        check("reset_addr", mem_addr, 0);
        check("reset_data", mem_data, 0);
        check("reset_ready", sample_ready, 0);
        check("reset_busy", busy, 1);
        check("reset_ptr", wr_ptr, 0);
        model_wipe();
        reset = 1'b1;
        count_lows(2000, n);
        check("ready_low_after_reset", n, 640);
        check("busy_idle", busy, 0);

        // Directed column: extremes on both channels.
        for (int i = 0; i < DECIM; i++) send(4095, 0, 0);

        // Random traffic long enough to wrap the trace pointer.
        for (int c = 0; c < 330; c++) begin
            for (int i = 0; i < DECIM; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clock);
                send(rnd_sample(), rnd_sample(), 0);
            end
        end

        // Partial group, then clear with a simultaneous sample: group must restart from zero.
        send(100, 200, 0);
        send(1234, 2345, 1);
        for (int i = 0; i < DECIM; i++) send(rnd_sample(), rnd_sample(), 0);

        // Clear during WR_EMG completes the sequence, then wipes.
        for (int i = 0; i < DECIM - 1; i++) send(rnd_sample(), rnd_sample(), 0);
        send(rnd_sample(), rnd_sample(), 2);
        for (int i = 0; i < DECIM; i++) send(rnd_sample(), rnd_sample(), 0);

        // Averaging column case (mean 1791 -> 78, last sample -> 179).
        send(0, 10, 0);
        send(1024, 20, 0);
        send(2048, 30, 0);
        send(4095, 40, 0);

        // Reset during the stat writes abandons the sequence.
        for (int i = 0; i < DECIM - 1; i++) send(rnd_sample(), rnd_sample(), 0);
        send(rnd_sample(), rnd_sample(), 3);
        for (int i = 0; i < 3 * DECIM; i++) send(rnd_sample(), rnd_sample(), 0);

        repeat (10) @(negedge clock);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
